// File: rtl/mkmif_burst_ctrl.sv
// Burst sequencer in front of mkmif_core: splits one burst command into single-word
// core ops, with address stepping, bounds checking and a per-word watchdog.
module mkmif_burst_ctrl #(
    parameter int          ADDR_STEP      = 4,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'h100000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_start,
    input  logic        cmd_write,
    input  logic [15:0] cmd_addr,
    input  logic [7:0]  cmd_len,
    output logic        cmd_busy,
    output logic        cmd_done,
    output logic        cmd_error,
    input  logic [31:0] wr_data,
    input  logic        wr_valid,
    output logic        wr_ready,
    output logic [31:0] rd_data,
    output logic        rd_valid,
    input  logic        rd_ready,
    output logic        core_write_op,
    output logic        core_read_op,
    output logic [15:0] core_addr,
    output logic [31:0] core_write_data,
    input  logic        core_ready,
    input  logic        core_valid,
    input  logic [31:0] core_read_data
);
    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_CHECK     = 3'd1;
    localparam logic [2:0] ST_ARM       = 3'd2;
    localparam logic [2:0] ST_WAIT_LOW  = 3'd3;
    localparam logic [2:0] ST_WAIT_DONE = 3'd4;
    localparam logic [2:0] ST_DRAIN     = 3'd5;
    localparam logic [2:0] ST_DONE      = 3'd6;

    logic [2:0]  state;
    logic [15:0] addr;
    logic [7:0]  remaining;
    logic        dir_write;
    logic [23:0] timer;
    logic [16:0] end_addr;
    logic        bad_cmd;
    logic        arm_go;
    logic        word_done;
    logic        timed_out;

    // 17-bit end address so a burst running past the top of the space cannot wrap
    assign end_addr  = {1'b0, addr} + 17'(ADDR_STEP) * {9'd0, remaining};
    assign bad_cmd   = (remaining == 8'd0) || (addr[1:0] != 2'b00) || (end_addr > 17'h10000);
    assign arm_go    = (state == ST_ARM) && core_ready && (dir_write ? wr_valid : !rd_valid);
    assign wr_ready  = arm_go && dir_write;
    assign word_done = (state == ST_WAIT_DONE) && core_ready && (dir_write || core_valid);
    assign timed_out = (timer == TIMEOUT_CYCLES - 24'd1);
    assign cmd_busy  = (state != ST_IDLE);
    assign cmd_done  = (state == ST_DONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= ST_IDLE;
            addr            <= '0;
            remaining       <= '0;
            dir_write       <= 1'b0;
            timer           <= '0;
            cmd_error       <= 1'b0;
            rd_data         <= '0;
            rd_valid        <= 1'b0;
            core_write_op   <= 1'b0;
            core_read_op    <= 1'b0;
            core_addr       <= '0;
            core_write_data <= '0;
        end else begin
            core_write_op <= 1'b0;
            core_read_op  <= 1'b0;
            if (rd_valid && rd_ready)
                rd_valid <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (cmd_start) begin
                        addr      <= cmd_addr;
                        remaining <= cmd_len;
                        dir_write <= cmd_write;
                        cmd_error <= 1'b0;
                        state     <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (bad_cmd) begin
                        cmd_error <= 1'b1;
                        state     <= ST_DONE;
                    end else begin
                        state <= ST_ARM;
                    end
                end
                ST_ARM: begin
                    // core samples addr/data the cycle after the op, so they stay put until the next op
                    if (arm_go) begin
                        core_addr <= addr;
                        if (dir_write) begin
                            core_write_data <= wr_data;
                            core_write_op   <= 1'b1;
                        end else begin
                            core_read_op <= 1'b1;
                        end
                        timer <= '0;
                        state <= ST_WAIT_LOW;
                    end
                end
                ST_WAIT_LOW: begin
                    timer <= timer + 24'd1;
                    if (timed_out) begin
                        cmd_error <= 1'b1;
                        state     <= ST_DONE;
                    end else if (!core_ready) begin
                        state <= ST_WAIT_DONE;
                    end
                end
                ST_WAIT_DONE: begin
                    timer <= timer + 24'd1;
                    if (word_done) begin
                        if (!dir_write) begin
                            rd_data  <= core_read_data;
                            rd_valid <= 1'b1;
                        end
                        addr      <= addr + 16'(ADDR_STEP);
                        remaining <= remaining - 8'd1;
                        state     <= (remaining == 8'd1) ? ST_DRAIN : ST_ARM;
                    end else if (timed_out) begin
                        cmd_error <= 1'b1;
                        state     <= ST_DONE;
                    end
                end
                ST_DRAIN: begin
                    if (!rd_valid)
                        state <= ST_DONE;
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: doc/mkmif_burst_ctrl.md
Name: mkmif_burst_ctrl

Overview:
Upstream sequencer for mkmif_core. It turns one burst command (start byte address, word count, direction) into a sequence of single-word write_op/read_op transactions on the core's command interface. Write data enters on a valid/ready stream; read data leaves on a valid/ready stream. The block adds address stepping, bounds checking, and a per-word watchdog so that a hung SPI transfer cannot stall the host.

Parameters:
ADDR_STEP, 4, byte address increment per 32-bit word.
TIMEOUT_CYCLES, 24'h100000, maximum clk cycles allowed per core transaction before the burst is aborted.

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
cmd_start  in  1  start burst; sampled only when cmd_busy=0
cmd_write  in  1  1=write burst, 0=read burst
cmd_addr  in  16  start byte address
cmd_len  in  8  number of 32-bit words
cmd_busy  out  1  burst in progress
cmd_done  out  1  one-cycle pulse at end of burst
cmd_error  out  1  status of last burst; sticky until next accepted cmd_start
wr_data  in  32  write word
wr_valid  in  1  write word available
wr_ready  out  1  write word consumed this cycle
rd_data  out  32  read word
rd_valid  out  1  read word available
rd_ready  in  1  consumer accepts rd_data
core_write_op  out  1  one-cycle write request to core
core_read_op  out  1  one-cycle read request to core
core_addr  out  16  word byte address to core
core_write_data  out  32  write word to core
core_ready  in  1  core idle and accepting ops
core_valid  in  1  core read data valid
core_read_data  in  32  core read word

Behaviour:
- Reset: all outputs 0; state IDLE; internal address, count and timer 0.
- All core_* outputs are registered. core_addr and core_write_data are held stable from the op pulse until the next op pulse, because the core samples them the cycle after the op.
- IDLE:
  - On cmd_start, latch addr, len and dir; clear cmd_error; set cmd_busy=1 on the next cycle; go to CHECK.
  - cmd_start while busy is ignored.
- CHECK (1 cycle): the burst is an error if cmd_len==0, or addr[1:0]!=0, or addr + ADDR_STEP*len > 17'h10000 (computed 17 bits wide, so no wrap). On error go to DONE with cmd_error=1; otherwise go to ARM.
- ARM: wait for core_ready=1 AND the direction condition:
  - Write: wr_valid=1. Assert wr_ready for exactly this cycle, latch wr_data into core_write_data, and pulse core_write_op next cycle.
  - Read: rd_valid=0. Pulse core_read_op next cycle.
  - In both cases core_addr = current address. Go to WAIT_LOW.
- WAIT_LOW: wait for core_ready=0 (the core drops ready the cycle after the op), then go to WAIT_DONE.
- WAIT_DONE: wait for core_ready=1.
  - Read: also require core_valid=1. Capture core_read_data into rd_data and set rd_valid.
  - Then address += ADDR_STEP and remaining -= 1. If remaining==0 go to DRAIN, else go to ARM.
- Watchdog:
  - The timer clears on entry to WAIT_LOW and increments in WAIT_LOW and WAIT_DONE.
  - Reaching TIMEOUT_CYCLES aborts: go to DONE with cmd_error=1. No further ops are issued and remaining stream words are not consumed.
- rd_valid clears on rd_valid & rd_ready. It is never overwritten while set, because ARM blocks the read.
- DRAIN: wait for rd_valid=0 (writes pass straight through), then go to DONE.
- DONE (1 cycle): cmd_done=1, cmd_busy=0 on the next cycle, go to IDLE.
- Only one op is outstanding at any time. core_write_op and core_read_op are never asserted together or on consecutive cycles.
- Minimum per-word overhead is 3 cycles plus the core transaction time.
- Reset mid-burst: immediate return to IDLE and all outputs 0. The external SRAM state is undefined and is the host's responsibility.

Test Plan:
- Write burst, addr=16'h0010, len=3, words A5A5_0001..0003, wr_valid always 1, core model ready after 20 cycles → core_write_op pulses with core_addr 0010/0014/0018 and matching data; wr_ready pulses 3 times; cmd_done pulse; cmd_error=0.
- Read burst, addr=16'h0100, len=2, core returns DEAD_BEEF then CAFE_F00D, rd_ready held 0 for 50 cycles after the first word → second core_read_op is not issued until the first word is accepted; both words delivered in order; done only after the last word is accepted.
- Error checks (len=0; addr=16'h0002; addr=16'hFFFC with len=2) → no core ops; cmd_done 2 cycles after start; cmd_error=1; wr_ready never asserted.
- Boundary: addr=16'hFFF8, len=2 → accepted; last core_addr=FFFC; cmd_error=0.
- Timeout, TIMEOUT_CYCLES=64, core never returns ready after the op → cmd_done at timer expiry; cmd_error=1; no further ops; the next valid burst runs cleanly with cmd_error cleared.
- Reset asserted in WAIT_DONE of word 2 of a 4-word write → all outputs 0 asynchronously; a new burst after release starts at its own cmd_addr.
